// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: PC-source encodings, nop word,
// fetch-stage state encoding and the IF/ID payload layout.
package mips_pkg;

    localparam logic [1:0]  PCSRC_SEQ = 2'b00;
    localparam logic [1:0]  PCSRC_BR  = 2'b01;
    localparam logic [1:0]  PCSRC_JMP = 2'b10;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_FETCH  = 2'd1,
        FS_BUFFER = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction + PC+4 + valid.
// Clear wins over enable and loads a bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_en,
    input  logic  i_clr,
    input  ifid_t i_d,
    output ifid_t o_q,
    output logic  o_valid
);

    ifid_t r_q;
    logic  r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '{instr: NOP_INSTR, pc4: 32'h0};
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_q     <= '{instr: NOP_INSTR, pc4: 32'h0};
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, one-entry fetch buffer and
// IF/ID register feeding decode. Jump target is formed from the IF/ID contents.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCbranch_D,
    input  logic [1:0]  PC_src_D,
    input  logic        stall_FD,
    input  logic        flush_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] instr_D,
    output logic [31:0] PCPlus4_D,
    output logic        valid_D
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, w_pc4, w_target;
    ifid_t        r_buf, w_avail_word, w_ifid;
    logic         w_accept, w_avail, w_redirect, w_buf_ld, w_ifid_en, w_ifid_clr;

    assign w_pc4      = r_pc + 32'd4;
    assign w_accept   = (r_state == FS_FETCH) && imem_ready;
    assign w_avail    = w_accept || (r_state == FS_BUFFER);
    assign w_redirect = (PC_src_D != PCSRC_SEQ) && !stall_FD;
    // Bit 1 of PC_src selects jump over branch; jump index comes from IF/ID.
    assign w_target   = PC_src_D[1] ? {PCPlus4_D[31:28], instr_D[25:0], 2'b00} : PCbranch_D;

    assign w_avail_word = (r_state == FS_BUFFER) ? r_buf : '{instr: imem_rdata, pc4: w_pc4};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FS_BOOT;
            r_pc    <= RESET_PC;
            r_buf   <= '{instr: NOP_INSTR, pc4: 32'h0};
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_buf_ld) r_buf <= '{instr: imem_rdata, pc4: w_pc4};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_ld    = 1'b0;
        w_ifid_en   = 1'b0;
        w_ifid_clr  = 1'b0;
        if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_state_nxt = FS_FETCH;
            w_ifid_clr  = 1'b1;
        end else begin
            if (w_accept) w_pc_nxt = w_pc4;
            if (stall_FD || flush_D) begin
                // Hold or bubble IF/ID; a freshly accepted word parks in the buffer.
                w_ifid_clr = !stall_FD;
                if (w_accept) begin
                    w_buf_ld    = 1'b1;
                    w_state_nxt = FS_BUFFER;
                end else if (r_state == FS_BOOT) begin
                    w_state_nxt = FS_FETCH;
                end
            end else begin
                w_state_nxt = FS_FETCH;
                w_ifid_en   = w_avail;
                w_ifid_clr  = !w_avail;
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_ifid_en),
        .i_clr   (w_ifid_clr),
        .i_d     (w_avail_word),
        .o_q     (w_ifid),
        .o_valid (valid_D)
    );

    assign imem_req  = (r_state == FS_FETCH);
    assign imem_addr = r_pc;
    assign PC_F      = r_pc;
    assign instr_D   = w_ifid.instr;
    assign PCPlus4_D = w_ifid.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-wait combinational instruction memory.
// Each check compares {imem_req, imem_addr, PC_F, instr_D, PCPlus4_D, valid_D}.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PCbranch_D = 32'h0;
    logic [1:0]  PC_src_D = 2'b00;
    logic        stall_FD = 1'b0;
    logic        flush_D = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        imem_req, valid_D;
    logic [31:0] imem_addr, PC_F, instr_D, PCPlus4_D;

    int n_cmp = 0;
    int n_err = 0;
    logic [129:0] obs, exp_v;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .PCbranch_D(PCbranch_D), .PC_src_D(PC_src_D),
        .stall_FD(stall_FD), .flush_D(flush_D), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_F(PC_F), .instr_D(instr_D),
        .PCPlus4_D(PCPlus4_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h1000_0004) ? 32'h0800_0010 : (32'hE000_0000 | a);
    endfunction

    always_comb imem_rdata = mem(imem_addr);
    assign obs = {imem_req, imem_addr, PC_F, instr_D, PCPlus4_D, valid_D};

    function automatic logic [129:0] ev(input logic r, input logic [31:0] pc,
                                        input logic [31:0] ins, input logic [31:0] p4, input logic v);
        return {r, pc, pc, ins, p4, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        exp_v = ev(0, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_hold got %h exp %h", obs, exp_v); end
        n_cmp++;
        reset = 1'b1;
        exp_v = ev(0, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL boot got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL fetch0 got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h4, 32'hE000_0000, 32'h4, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL fetch4 got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h8, 32'hE000_0004, 32'h8, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL fetch8 got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = ev(1, 32'h8, 32'h0, 32'h0, 0);
            if (obs !== exp_v) begin n_err++; $display("FAIL nordy_%0d got %h exp %h", i, obs, exp_v); end
            n_cmp++;
        end
        imem_ready = 1'b1;
        step();
        exp_v = ev(1, 32'hC, 32'hE000_0008, 32'hC, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL rdy_resume got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_stall();
        stall_FD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = ev(0, 32'h10, 32'hE000_0008, 32'hC, 1);
            if (obs !== exp_v) begin n_err++; $display("FAIL stall_%0d got %h exp %h", i, obs, exp_v); end
            n_cmp++;
        end
        stall_FD = 1'b0;
        step();
        exp_v = ev(1, 32'h10, 32'hE000_000C, 32'h10, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL stall_buf got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h14, 32'hE000_0010, 32'h14, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL stall_resume got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_branch();
        PC_src_D = 2'b01; PCbranch_D = 32'h40;
        step();
        PC_src_D = 2'b00;
        exp_v = ev(1, 32'h40, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL br_bubble got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h44, 32'hE000_0040, 32'h44, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL br_target got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_flush();
        flush_D = 1'b1;
        step();
        flush_D = 1'b0;
        exp_v = ev(0, 32'h48, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL flush_bubble got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h48, 32'hE000_0044, 32'h48, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL flush_buf got %h exp %h", obs, exp_v); end
        n_cmp++;
        // Redirect request must be ignored while stalled.
        stall_FD = 1'b1; PC_src_D = 2'b01; PCbranch_D = 32'h200;
        step();
        exp_v = ev(0, 32'h4C, 32'hE000_0044, 32'h48, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL stall_ignbr got %h exp %h", obs, exp_v); end
        n_cmp++;
        stall_FD = 1'b0; PC_src_D = 2'b00;
        step();
        exp_v = ev(1, 32'h4C, 32'hE000_0048, 32'h4C, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL ignbr_buf got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h50, 32'hE000_004C, 32'h50, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL ignbr_seq got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_jump();
        PC_src_D = 2'b01; PCbranch_D = 32'h1000_0000;
        step();
        PC_src_D = 2'b00;
        step();
        exp_v = ev(1, 32'h1000_0004, 32'hF000_0000, 32'h1000_0004, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp_pre0 got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp_pre1 got %h exp %h", obs, exp_v); end
        n_cmp++;
        PC_src_D = 2'b10;
        step();
        PC_src_D = 2'b00;
        exp_v = ev(1, 32'h1000_0040, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp10 got %h exp %h", obs, exp_v); end
        n_cmp++;
        PC_src_D = 2'b01; PCbranch_D = 32'h1000_0004;
        step();
        PC_src_D = 2'b00;
        step();
        exp_v = ev(1, 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp_pre2 got %h exp %h", obs, exp_v); end
        n_cmp++;
        PC_src_D = 2'b11; PCbranch_D = 32'h0000_0300;
        step();
        PC_src_D = 2'b00;
        exp_v = ev(1, 32'h1000_0040, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp11 got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h1000_0044, 32'hF000_0040, 32'h1000_0044, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL jmp_target got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_wrap();
        PC_src_D = 2'b01; PCbranch_D = 32'hFFFF_FFFC;
        step();
        PC_src_D = 2'b00;
        exp_v = ev(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_br got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_pc got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h4, 32'hE000_0000, 32'h4, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_next got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    task automatic test_reset_buffer();
        stall_FD = 1'b1;
        step();
        exp_v = ev(0, 32'h8, 32'hE000_0000, 32'h4, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL rb_buffer got %h exp %h", obs, exp_v); end
        n_cmp++;
        reset = 1'b0;
        #1;
        exp_v = ev(0, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL rb_async got %h exp %h", obs, exp_v); end
        n_cmp++;
        stall_FD = 1'b0;
        step(); step();
        reset = 1'b1;
        exp_v = ev(0, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL rb_boot got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h0, 32'h0, 32'h0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL rb_fetch0 got %h exp %h", obs, exp_v); end
        n_cmp++;
        step();
        exp_v = ev(1, 32'h4, 32'hE000_0000, 32'h4, 1);
        if (obs !== exp_v) begin n_err++; $display("FAIL rb_fetch4 got %h exp %h", obs, exp_v); end
        n_cmp++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ready_low();
        test_stall();
        test_branch();
        test_flush();
        test_jump();
        test_wrap();
        test_reset_buffer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of `decode_stage`. It owns the program counter, the instruction-memory request handshake, a one-entry fetch buffer and the IF/ID pipeline register that drives `instr_D` and `PCPlus4_D` into decode. It consumes decode's redirect outputs (`PC_src_D`, `PCbranch_D`) and forms the jump target itself from the IF/ID register.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `PCbranch_D`  in  32  branch target from decode.
- `PC_src_D`  in  2  from decode: 00 sequential, 01 branch, 1x jump (bit 1 has priority).
- `stall_FD`  in  1  hazard-unit stall; freezes PC consumption and IF/ID.
- `flush_D`  in  1  hazard-unit flush; loads a bubble into IF/ID.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `PC_F`.
- `imem_ready`  in  1  memory accepts request and returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_req && imem_ready`.
- `PC_F`  out  32  address of the next instruction to fetch.
- `instr_D`  out  32  IF/ID instruction; 32'h0 (nop) when bubble.
- `PCPlus4_D`  out  32  IF/ID PC+4 of `instr_D`.
- `valid_D`  out  1  IF/ID holds a real instruction.

## Operation
- States: BOOT, FETCH, BUFFER.
- BOOT: entered on reset; `imem_req`=0; unconditionally -> FETCH next cycle.
- FETCH: `imem_req`=1. Accept = `imem_ready`. On accept PC_F <= PC_F+4; word and its PC+4 are "available".
- BUFFER: `imem_req`=0; buffered word and its PC+4 are "available"; PC_F already advanced.
- Redirect = `PC_src_D`!=00 and `stall_FD`=0. Target: jump = {PCPlus4_D[31:28], instr_D[25:0], 2'b00}; branch = `PCbranch_D`.
- Priority per edge: reset > redirect > stall > flush > normal.
- Redirect: PC_F <= target; any accepted or buffered word discarded; IF/ID <= bubble; state -> FETCH.
- Stall: IF/ID holds. If a word is accepted this cycle it is captured into the buffer, state -> BUFFER. BUFFER stays BUFFER.
- Flush (no stall): IF/ID <= bubble. An available word is retained in (or moved to) the buffer, state -> BUFFER.
- Normal: if a word is available, IF/ID <= {word, its PC+4}, `valid_D`=1, state -> FETCH. Otherwise IF/ID <= bubble.
- Bubble = `instr_D`=0, `PCPlus4_D`=0, `valid_D`=0.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. PC bits [1:0] are never forced; targets are used as given.

## Timing
- Reset (asynchronous assert, synchronous release): PC_F=RESET_PC, `instr_D`=0, `PCPlus4_D`=0, `valid_D`=0, `imem_req`=0, state BOOT, buffer empty.
- `imem_addr` and `imem_req` are combinational from registered state/PC; no input-to-output combinational path.
- Zero-wait memory: word accepted at edge N appears on `instr_D` after edge N; sustained throughput one instruction/cycle.
- Redirect at edge N: `imem_addr`=target in cycle N+1; target instruction reaches `instr_D` no earlier than edge N+1.
- `PC_src_D` is ignored while `stall_FD`=1.
- Reset mid-operation: all state reverts immediately, buffer discarded.

## Structure
- Shared package `mips_pkg`: PC_src encodings (PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JMP=2'b10), NOP_INSTR=32'h0, fetch state encoding.
- One sub-module: `if_id_reg` (64-bit+valid register with enable and synchronous clear, async active-low reset).

## Test plan
- Reset release, RESET_PC=0, `imem_ready`=1 always: `imem_addr` 0,4,8 on successive cycles; `instr_D` follows memory with `valid_D`=1 from third cycle after release.
- `imem_ready` low 3 cycles at PC=8: PC_F holds 8, IF/ID bubbles 3 cycles, then word@8 with `PCPlus4_D`=12.
- `stall_FD` 2 cycles with accept in first: state BUFFER, `imem_req`=0, `instr_D` held; on release buffered word loads, then fetch resumes at next PC.
- Branch: `PC_src_D`=01, `PCbranch_D`=32'h40: next `imem_addr`=32'h40, `valid_D`=0 one cycle, no instruction from old path reaches `instr_D`.
- Jump with `instr_D`=32'h0800_0010, `PCPlus4_D`=32'h1000_0008: next `imem_addr`=32'h1000_0040; `PC_src_D`=11 behaves identically.
- Assert `reset` low while in BUFFER: all outputs return to reset values asynchronously; first fetch after release at RESET_PC.
